mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester (if_) and the load/store requester (dm_) of the multi-cycle CPU.
- Sequences each access: latches the address, holds mem_on/mem_w/mem_addr for a fixed wait time, captures the read data, and returns a one-cycle acknowledge.
- Sits between the fetch/execute stage controllers and the memory model.
- Replaces ad hoc delay-based memory timing with clocked handshakes.

Parameters:
- WORD_SIZE, 32, width of address and data words.
- MEM_LATENCY, 2, cycles mem_on is held per access. Must be at least 1; a value of 0 is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  WORD_SIZE  fetch address (PC).
- if_ack  output  1  one-cycle pulse; fetch access complete.
- if_gnt  output  1  high while the fetch transaction owns the port.
- dm_req  input  1  data request; held high until dm_ack.
- dm_w  input  1  1 = store, 0 = load.
- dm_addr  input  WORD_SIZE  data address.
- dm_wdata  input  WORD_SIZE  store data.
- dm_ack  output  1  one-cycle pulse; data access complete.
- dm_gnt  output  1  high while the data transaction owns the port.
- rdata  output  WORD_SIZE  read data, valid in the ack cycle and held until the next capture.
- mem_on  output  1  memory enable.
- mem_w  output  1  memory write enable.
- mem_addr  output  WORD_SIZE  memory address.
- mem_data_in  output  WORD_SIZE  memory write data.
- mem_data_out  input  WORD_SIZE  memory read data.

Behaviour:
- Reset (asynchronous): all outputs are 0, state is IDLE, cnt = 0, and last_owner = FETCH (this makes data win the first tie).
- States and transitions:
  - IDLE: on an edge with if_req or dm_req high, select the owner and go to BUSY. Latch addr, w and wdata into the mem_* registers, set mem_on = 1 and set cnt = MEM_LATENCY-1.
  - BUSY: mem_on stays 1, and mem_addr, mem_w and mem_data_in are held stable.
    - If cnt != 0: cnt decrements.
    - If cnt == 0: capture mem_data_out into rdata (loads and fetches only; stores leave rdata unchanged), drop mem_on and mem_w to 0, pulse the owner's ack, and go to DONE.
  - DONE: the ack is high for exactly this cycle. Go to IDLE unconditionally on the next edge.
- Grant: if_gnt/dm_gnt is high in BUSY and DONE for the owner only. The two grants are never high together.
- Arbitration when both requests are high in IDLE: the owner is the requester not granted last (alternating). last_owner updates when BUSY is entered.
- If only one request is high, that requester is granted regardless of last_owner.
- Fetch accesses always have mem_w = 0. mem_data_in is don't-care on reads and is driven to 0.
- Timing: the request is sampled at edge E0 and mem_on is high for MEM_LATENCY cycles. The ack is high in the cycle after edge E0+MEM_LATENCY.
  - Request-to-ack latency is MEM_LATENCY+1 cycles.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Requester rule: req must be low by the edge that follows the ack cycle. The DONE cycle ignores req, so a requester that drops req off the registered ack is never double-served.
- Request inputs change only in IDLE-relevant windows. Address and data are sampled only at the IDLE-to-BUSY edge; later changes have no effect.
- A new request arriving while BUSY waits; it is not lost, because req is held.
- Reset asserted mid-transaction aborts it: no ack is issued, mem_on drops immediately (asynchronously), and rdata returns to 0.

Test Plan:
- Fetch only, MEM_LATENCY=2, if_addr=0x0000_0040, memory returns 0x2108_0001 → mem_on high for 2 cycles with mem_addr=0x40 and mem_w=0; if_ack pulses 3 cycles after the request; rdata=0x2108_0001.
- Store, dm_w=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF → mem_w=1, mem_data_in=0xDEADBEEF for 2 cycles; dm_ack pulses once; rdata unchanged.
- if_req and dm_req rise in the same cycle after reset → data served first (dm_gnt); fetch granted at the IDLE edge following dm_ack; no overlap of mem_on between the two transactions.
- Both requesters hold req continuously, re-raising it after each ack → grants alternate D, F, D, F; each access takes 4 cycles at MEM_LATENCY=2.
- rst asserted in the second BUSY cycle of a load → mem_on=0 and rdata=0 immediately; no ack; after reset release, the still-high req is re-served from IDLE.
- MEM_LATENCY=1 build, single fetch → mem_on for 1 cycle; ack 2 cycles after the request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store requesters
module mem_port_arbiter #(
    parameter int WORD_SIZE   = 32,
    parameter int MEM_LATENCY = 2    // cycles mem_on is held; must be >= 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic                 if_ack,
    output logic                 if_gnt,
    input  logic                 dm_req,
    input  logic                 dm_w,
    input  logic [WORD_SIZE-1:0] dm_addr,
    input  logic [WORD_SIZE-1:0] dm_wdata,
    output logic                 dm_ack,
    output logic                 dm_gnt,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 mem_on,
    output logic                 mem_w,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data_in,
    input  logic [WORD_SIZE-1:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Counter only needs to hold MEM_LATENCY-1.
    localparam int            CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   owner_dm, owner_dm_n;   // 1 = data owns the port
    logic                   last_dm, last_dm_n;     // 1 = data was granted last
    logic                   mem_on_n, mem_w_n;
    logic [WORD_SIZE-1:0]   mem_addr_n, mem_data_in_n, rdata_n;
    logic                   if_ack_n, dm_ack_n, if_gnt_n, dm_gnt_n;
    logic                   pick_dm;

    // Both requests pending: alternate away from the last owner; otherwise take whoever asks.
    assign pick_dm = (if_req && dm_req) ? ~last_dm : dm_req;

    // State and all registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            owner_dm    <= 1'b0;
            last_dm     <= 1'b0;
            mem_on      <= 1'b0;
            mem_w       <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            rdata       <= '0;
            if_ack      <= 1'b0;
            dm_ack      <= 1'b0;
            if_gnt      <= 1'b0;
            dm_gnt      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            owner_dm    <= owner_dm_n;
            last_dm     <= last_dm_n;
            mem_on      <= mem_on_n;
            mem_w       <= mem_w_n;
            mem_addr    <= mem_addr_n;
            mem_data_in <= mem_data_in_n;
            rdata       <= rdata_n;
            if_ack      <= if_ack_n;
            dm_ack      <= dm_ack_n;
            if_gnt      <= if_gnt_n;
            dm_gnt      <= dm_gnt_n;
        end
    end

    // Next-state and next-output logic for the IDLE -> BUSY -> DONE access sequence.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        owner_dm_n    = owner_dm;
        last_dm_n     = last_dm;
        mem_on_n      = mem_on;
        mem_w_n       = mem_w;
        mem_addr_n    = mem_addr;
        mem_data_in_n = mem_data_in;
        rdata_n       = rdata;
        if_ack_n      = 1'b0;
        dm_ack_n      = 1'b0;
        if_gnt_n      = if_gnt;
        dm_gnt_n      = dm_gnt;

        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    owner_dm_n    = pick_dm;
                    last_dm_n     = pick_dm;
                    mem_on_n      = 1'b1;
                    mem_w_n       = pick_dm & dm_w;
                    mem_addr_n    = pick_dm ? dm_addr : if_addr;
                    mem_data_in_n = (pick_dm && dm_w) ? dm_wdata : '0;
                    cnt_n         = CNT_INIT;
                    if_gnt_n      = ~pick_dm;
                    dm_gnt_n      = pick_dm;
                    state_n       = BUSY;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    // Stores keep the previous read data.
                    if (!mem_w) begin
                        rdata_n = mem_data_out;
                    end
                    mem_on_n = 1'b0;
                    mem_w_n  = 1'b0;
                    dm_ack_n = owner_dm;
                    if_ack_n = ~owner_dm;
                    state_n  = DONE;
                end
            end
            DONE: begin
                // Requests are ignored here so a requester dropping req off the ack is not re-served.
                if_gnt_n = 1'b0;
                dm_gnt_n = 1'b0;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int W   = 32;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req, dm_req, dm_w;
    logic [W-1:0] if_addr, dm_addr, dm_wdata;
    logic         if_ack, if_gnt, dm_ack, dm_gnt;
    logic [W-1:0] rdata, mem_addr, mem_data_in, mem_data_out;
    logic         mem_on, mem_w;

    // MEM_LATENCY=1 instance, fetch only
    logic         rst1;
    logic         l1_if_req, l1_dm_req, l1_dm_w;
    logic [W-1:0] l1_if_addr, l1_dm_addr, l1_dm_wdata;
    logic         l1_if_ack, l1_if_gnt, l1_dm_ack, l1_dm_gnt;
    logic [W-1:0] l1_rdata, l1_mem_addr, l1_mem_data_in, l1_mem_data_out;
    logic         l1_mem_on, l1_mem_w;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Memory returns an address-derived word while enabled, garbage otherwise.
    function automatic logic [W-1:0] mem_fn(input logic [W-1:0] a, input logic on);
        return on ? {a[15:0] ^ 16'h2108, a[31:16] + 16'h0001} : 32'hBAD0_BAD0;
    endfunction

    assign mem_data_out    = mem_fn(mem_addr, mem_on);
    assign l1_mem_data_out = mem_fn(l1_mem_addr, l1_mem_on);

    mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_gnt(if_gnt),
        .dm_req(dm_req), .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_gnt(dm_gnt), .rdata(rdata),
        .mem_on(mem_on), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst1),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_ack(l1_if_ack), .if_gnt(l1_if_gnt),
        .dm_req(l1_dm_req), .dm_w(l1_dm_w), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
        .dm_ack(l1_dm_ack), .dm_gnt(l1_dm_gnt), .rdata(l1_rdata),
        .mem_on(l1_mem_on), .mem_w(l1_mem_w), .mem_addr(l1_mem_addr),
        .mem_data_in(l1_mem_data_in), .mem_data_out(l1_mem_data_out)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: ph counts cycles since the grant edge (0 = port idle,
    // 1..LAT = memory enabled, LAT+1 = ack cycle).
    int           ph;
    bit           m_own_dm, m_last_dm, m_w;
    logic [W-1:0] m_addr, m_wdata, m_rdata;

    task automatic model_reset();
        ph        = 0;
        m_own_dm  = 1'b0;
        m_last_dm = 1'b0;
        m_w       = 1'b0;
        m_rdata   = '0;
    endtask

    task automatic model_step();
        bit pick;
        if (ph == 0) begin
            if (if_req || dm_req) begin
                pick      = (if_req && dm_req) ? !m_last_dm : dm_req;
                m_own_dm  = pick;
                m_last_dm = pick;
                m_w       = pick && dm_w;
                m_addr    = pick ? dm_addr : if_addr;
                m_wdata   = m_w ? dm_wdata : '0;
                ph        = 1;
            end
        end else if (ph <= LAT) begin
            if (ph == LAT && !m_w) m_rdata = mem_fn(m_addr, 1'b1);
            ph++;
        end else begin
            ph = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_on"}, W'(mem_on), '0);
        check({tag, "_mem_w"},  W'(mem_w), '0);
        check({tag, "_rdata"},  rdata, '0);
        check({tag, "_gnt"},    W'({if_gnt, dm_gnt}), '0);
        check({tag, "_ack"},    W'({if_ack, dm_ack}), '0);
    endtask

    initial begin
        bit busy, done, forced, dropped_if, dropped_dm;
        int p, cnt;

        rst = 1'b1; rst1 = 1'b1;
        if_req = 0; dm_req = 0; dm_w = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
        l1_if_req = 0; l1_dm_req = 0; l1_dm_w = 0;
        l1_if_addr = '0; l1_dm_addr = '0; l1_dm_wdata = '0;
        model_reset();
        #1;
        check_all_zero("reset");

        // MEM_LATENCY=1: single fetch, ack two cycles after the request.
        @(negedge clk); rst1 = 1'b0;
        @(negedge clk);
        l1_if_req = 1'b1; l1_if_addr = 32'h0000_0040;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                check("l1_mem_on_c1", W'(l1_mem_on), 1);
                check("l1_mem_addr", l1_mem_addr, 32'h40);
            end
        end while (!l1_if_ack && cnt < 10);
        check("l1_ack_latency", W'(cnt), 2);
        check("l1_mem_on_ack", W'(l1_mem_on), 0);
        check("l1_rdata", l1_rdata, mem_fn(32'h40, 1'b1));
        l1_if_req = 1'b0;
        @(negedge clk);
        check("l1_ack_pulse", W'(l1_if_ack), 0);

        // Main randomized run; both requesters rise together right after reset.
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b1; if_addr = $urandom;
        dm_req = 1'b1; dm_w = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom;
        model_step();
        forced = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            busy = (ph >= 1) && (ph <= LAT);
            done = (ph == LAT + 1);
            check("mem_on", W'(mem_on), W'(busy));
            check("if_gnt", W'(if_gnt), W'((ph >= 1) && !m_own_dm));
            check("dm_gnt", W'(dm_gnt), W'((ph >= 1) && m_own_dm));
            check("if_ack", W'(if_ack), W'(done && !m_own_dm));
            check("dm_ack", W'(dm_ack), W'(done && m_own_dm));
            check("rdata", rdata, m_rdata);
            if (busy) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_w", W'(mem_w), W'(m_w));
                check("mem_data_in", mem_data_in, m_wdata);
            end else begin
                check("mem_w_idle", W'(mem_w), 0);
            end

            if (rst) begin
                rst = 1'b0;
            end else if (cyc > 20 && busy &&
                         ((ph == 2 && !forced) || $urandom_range(0, 99) == 0)) begin
                forced = 1;
                rst = 1'b1;
                #1;
                check_all_zero("midrst");
                model_reset();
                continue;
            end

            // Requesters: drop off the ack, otherwise raise at random; scramble
            // inputs that must already have been sampled.
            dropped_if = 0; dropped_dm = 0;
            if (done && !m_own_dm) begin if_req = 1'b0; dropped_if = 1; end
            if (done && m_own_dm)  begin dm_req = 1'b0; dropped_dm = 1; end
            p = ((cyc / 500) % 2 == 1) ? 100 : 40;
            if (!if_req && !dropped_if && $urandom_range(1, 100) <= p) begin
                if_req = 1'b1; if_addr = $urandom;
            end else if (ph >= 1 && !m_own_dm) begin
                if_addr = $urandom;
            end
            if (!dm_req && !dropped_dm && $urandom_range(1, 100) <= p) begin
                dm_req = 1'b1; dm_w = $urandom_range(0, 1);
                dm_addr = $urandom; dm_wdata = $urandom;
            end else if (ph >= 1 && m_own_dm) begin
                dm_w = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom;
            end
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
